// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_ALL_ON = 2'd3
  } mode_e;

  localparam int NLEDS_DEFAULT = 5;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, stability debouncer and rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic I,
  output logic O,
  output logic RISE
);

  logic                     s1_q, s2_q, lvl_q, rise_q;
  logic [DEBOUNCE_BITS-1:0] cnt_q;

  // The counter only runs while the synced input disagrees with the accepted level.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= I;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (&cnt_q) begin
        lvl_q  <= s2_q;
        cnt_q  <= '0;
        rise_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign O    = lvl_q;
  assign RISE = rise_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaler tick, button-driven mode FSM, registered LED decode.
// Optional build macro LED_SEQ_PWM_EN: 25% duty gating of D in ALL_ON mode.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_BITS     = 22,
  parameter int DEBOUNCE_BITS = 16,
  parameter int NLEDS         = NLEDS_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             BTN,
  input  logic             EN,
  output logic [NLEDS-1:0] D,
  output logic [1:0]       MODE,
  output logic             TICK
);

  localparam logic [2:0] LAST = 3'(NLEDS - 1);

  logic                 btn_lvl, btn_rise, adv;
  logic [TICK_BITS-1:0] pre_q, pre_d;
  mode_e                mode_q, mode_d;
  logic [2:0]           pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic                 phase_q, phase_d;
  logic [NLEDS-1:0]     d_q, d_d;
  logic                 gate_on;

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_btn (
    .CLK   (CLK),
    .RESETN(RESETN),
    .I     (BTN),
    .O     (btn_lvl),
    .RISE  (btn_rise)
  );

  assign adv  = btn_rise & btn_lvl;
  assign TICK = EN & (&pre_q);

`ifdef LED_SEQ_PWM_EN
  logic [1:0] pwm_q, pwm_d;
  assign pwm_d   = pwm_q + 2'd1;
  assign gate_on = (pwm_d == 2'd0);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) pwm_q <= 2'd0;
    else         pwm_q <= pwm_d;
  end
`else
  assign gate_on = 1'b1;
`endif

  always_comb begin
    pre_d   = pre_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    // A mode advance restarts the step timebase and discards any coincident tick.
    if (adv) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      pre_d   = '0;
      pos_d   = '0;
      dir_d   = 1'b1;
      phase_d = 1'b0;
    end else begin
      if (EN) pre_d = pre_q + 1'b1;
      if (TICK) begin
        case (mode_q)
          MODE_BLINK: phase_d = ~phase_q;
          MODE_CHASE: pos_d = (pos_q == LAST) ? 3'd0 : pos_q + 3'd1;
          MODE_BOUNCE: begin
            if (dir_q) begin
              if (pos_q == LAST) begin
                pos_d = pos_q - 3'd1;
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q + 3'd1;
              end
            end else begin
              if (pos_q == 3'd0) begin
                pos_d = 3'd1;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q - 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    d_d = '0;
    case (mode_d)
      MODE_BLINK:               d_d = phase_d ? '1 : '0;
      MODE_CHASE, MODE_BOUNCE:  d_d = NLEDS'(onehot8(pos_d));
      default:                  d_d = gate_on ? '1 : '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q   <= '0;
      mode_q  <= MODE_BLINK;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      phase_q <= 1'b0;
      d_q     <= '0;
    end else begin
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      d_q     <= d_d;
    end
  end

  assign D    = d_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized scoreboard bench for led_seq_ctrl against a step-count reference model.
module tb_led_seq_ctrl;

  localparam int TB  = 3;
  localparam int DB  = 2;
  localparam int N   = 5;
  localparam int P   = 1 << TB;
  localparam int DBN = 1 << DB;
  localparam int BP  = 2 * (N - 1);

  logic         CLK = 1'b0;
  logic         RESETN, BTN, EN;
  logic [N-1:0] D;
  logic [1:0]   MODE;
  logic         TICK;

  led_seq_ctrl #(.TICK_BITS(TB), .DEBOUNCE_BITS(DB), .NLEDS(N)) dut (
    .CLK(CLK), .RESETN(RESETN), .BTN(BTN), .EN(EN),
    .D(D), .MODE(MODE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0] d;
    logic [1:0]   mode;
    logic         tick;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: steps counted abstractly, LED pattern derived from the count.
  int m_pre, m_mode, m_phase, m_k, m_s1, m_s2, m_lvl, m_run, m_advp, m_pwm;

  task automatic model_reset();
    m_pre = 0; m_mode = 0; m_phase = 0; m_k = 0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_advp = 0; m_pwm = 0;
  endtask

  function automatic logic [N-1:0] model_d();
    int j, pos;
    logic [N-1:0] allon;
    allon = '1;
    case (m_mode)
      0: return (m_phase != 0) ? allon : '0;
      1: return N'(1 << (m_k % N));
      2: begin
        j   = m_k % BP;
        pos = (j < N) ? j : BP - j;
        return N'(1 << pos);
      end
      default: begin
`ifdef LED_SEQ_PWM_EN
        return (m_pwm == 0) ? allon : '0;
`else
        return allon;
`endif
      end
    endcase
  endfunction

  task automatic model_edge(input bit en, input bit btn);
    bit tick;
    tick = en && (m_pre == P - 1);
    if (m_advp != 0) begin
      m_mode = (m_mode + 1) % 4; m_pre = 0; m_k = 0; m_phase = 0;
    end else begin
      if (en) m_pre = (m_pre + 1) % P;
      if (tick) begin
        if (m_mode == 0) m_phase = 1 - m_phase;
        else if (m_mode == 1 || m_mode == 2) m_k++;
      end
    end
    m_advp = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == DBN) begin
        m_lvl = m_s2; m_run = 0; m_advp = m_s2;
      end
    end else begin
      m_run = 0;
    end
    m_s2  = m_s1;
    m_s1  = btn ? 1 : 0;
    m_pwm = (m_pwm + 1) % 4;
  endtask

  task automatic cycle(input bit rst_n, input bit btn, input bit en);
    exp_t e;
    @(posedge CLK);
    #2;
    RESETN = rst_n; BTN = btn; EN = en;
    cyc++;
    if (!rst_n) begin
      model_reset();
      e = '{d: '0, mode: 2'd0, tick: 1'b0};
    end else begin
      e.d    = model_d();
      e.mode = 2'(m_mode);
      e.tick = en && (m_pre == P - 1);
      model_edge(en, btn);
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({D, MODE, TICK} !== {e.d, e.mode, e.tick}) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got D=%b MODE=%0d TICK=%b, want D=%b MODE=%0d TICK=%b",
                   cyc, D, MODE, TICK, e.d, e.mode, e.tick);
        end
      end
    end
  end

  initial begin : stim
    int r, len;
    bit lvl, en_seg;
    RESETN = 1'b0; BTN = 1'b0; EN = 1'b0;
    model_reset();
    repeat (3) cycle(0, 0, 0);
    repeat (40) cycle(1, 0, 1);
    repeat (10) cycle(1, 1, 1);
    repeat (60) cycle(1, 0, 1);
    repeat (3)  cycle(1, 1, 1);
    repeat (30) cycle(1, 0, 1);
    repeat (20) cycle(1, 0, 0);
    lvl = 1'b0;
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        repeat ($urandom_range(1, 2)) cycle(0, lvl, 1);
        model_reset();
      end else begin
        lvl    = ~lvl;
        len    = (r < 35) ? $urandom_range(1, 6) : $urandom_range(8, 90);
        en_seg = (r % 7) != 0;
        for (int c = 0; c < len; c++)
          cycle(1, lvl, en_seg && ($urandom_range(0, 9) != 0));
      end
    end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
